// File: rtl/fm_pkg.sv
// Shared types and constants for the feature-map ping-pong buffer.
package fm_pkg;
  localparam int FM_CONV_OUT_NUM = 18;
  localparam int FM_DATA_WIDTH   = 8;
  localparam int FM_WORD_W       = FM_CONV_OUT_NUM * FM_DATA_WIDTH;
  localparam int FM_MEM_DEPTH_D  = 13;
  localparam int FM_BANK_WORDS   = 1 << (FM_MEM_DEPTH_D - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BANK,
    FILL
  } fm_state_e;
endpackage

// File: rtl/fm_tile_addr_gen.sv
// Tile-relative address generator: col/row counters and row_base accumulator.
module fm_tile_addr_gen #(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          step,
  input  logic [DW-1:0] cfg_width,
  input  logic [DW-1:0] cfg_height,
  input  logic [AW-1:0] cfg_stride,
  output logic [AW-1:0] offset,
  output logic          at_start,
  output logic          last
);
  logic [DW-1:0] col, row;
  logic [AW-1:0] row_base;
  logic          col_end;

  assign col_end  = (col == cfg_width - DW'(1));
  assign last     = col_end && (row == cfg_height - DW'(1));
  assign at_start = (col == '0) && (row == '0);
  // Truncated sum keeps every write inside the current bank.
  assign offset   = row_base + AW'(col);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (clear) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (step) begin
      if (col_end) begin
        col      <= '0;
        row      <= row + DW'(1);
        row_base <= row_base + cfg_stride;
      end else begin
        col <= col + DW'(1);
      end
    end
  end
endmodule

// File: rtl/fm_mem_wr_ctrl.sv
// Write-side controller: places pre-process words into the ping-pong bank
// being filled and hands full banks to the convolution reader.
module fm_mem_wr_ctrl
  import fm_pkg::*;
#(
  parameter int CONV_OUT_NUM = FM_CONV_OUT_NUM,
  parameter int DATA_WIDTH   = FM_DATA_WIDTH,
  parameter int FM_MEM_DEPTH = FM_MEM_DEPTH_D,
  parameter int DIM_WIDTH    = 8
) (
  input  logic                             sys_clk,
  input  logic                             rstn,
  input  logic                             cfg_valid,
  input  logic [DIM_WIDTH-1:0]             cfg_width,
  input  logic [DIM_WIDTH-1:0]             cfg_height,
  input  logic [FM_MEM_DEPTH-2:0]          cfg_stride,
  input  logic [CONV_OUT_NUM*DATA_WIDTH-1:0] wr_data,
  input  logic                             wr_en,
  input  logic [1:0]                       bank_release,
  output logic [FM_MEM_DEPTH-1:0]          mem_wr_addr,
  output logic [CONV_OUT_NUM*DATA_WIDTH-1:0] mem_wr_data,
  output logic                             mem_wr_en,
  output logic [1:0]                       bank_full,
  output logic                             tile_done,
  output logic                             err_overflow
);
  localparam int AW = FM_MEM_DEPTH - 1;

  fm_state_e            state, state_nxt;
  logic                 cur_bank;
  logic [DIM_WIDTH-1:0] width_q, height_q;
  logic [AW-1:0]        stride_q;
  logic [AW-1:0]        offset;
  logic                 at_start, last;
  logic                 accept, tile_end, cfg_take, free_cur, free_oth;
  logic [1:0]           full_set, full_nxt;

  assign accept   = (state == FILL) && wr_en;
  assign tile_end = accept && last;
  assign cfg_take = cfg_valid && ((state != FILL) || at_start);
  // A release in the current cycle already counts as free.
  assign free_cur = !bank_full[cur_bank]  || bank_release[cur_bank];
  assign free_oth = !bank_full[~cur_bank] || bank_release[~cur_bank];

  fm_tile_addr_gen #(.AW(AW), .DW(DIM_WIDTH)) u_addr (
    .clk       (sys_clk),
    .rstn      (rstn),
    .clear     (cfg_take || tile_end),
    .step      (accept),
    .cfg_width (width_q),
    .cfg_height(height_q),
    .cfg_stride(stride_q),
    .offset    (offset),
    .at_start  (at_start),
    .last      (last)
  );

  always_comb begin
    state_nxt = state;
    full_set  = '0;
    case (state)
      IDLE:      if (cfg_take) state_nxt = free_cur ? FILL : WAIT_BANK;
      WAIT_BANK: if (free_cur) state_nxt = FILL;
      FILL:      if (tile_end) state_nxt = free_oth ? FILL : WAIT_BANK;
      default:   state_nxt = IDLE;
    endcase
    if (tile_end) full_set[cur_bank] = 1'b1;
    // Set after release so a same-cycle set wins.
    full_nxt = (bank_full & ~bank_release) | full_set;
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      cur_bank     <= 1'b0;
      width_q      <= '0;
      height_q     <= '0;
      stride_q     <= '0;
      bank_full    <= '0;
      mem_wr_en    <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      tile_done    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state     <= state_nxt;
      bank_full <= full_nxt;
      mem_wr_en <= accept;
      tile_done <= tile_end;
      if (cfg_take) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        stride_q <= cfg_stride;
      end
      if (accept) begin
        mem_wr_addr <= {cur_bank, offset};
        mem_wr_data <= wr_data;
      end
      if (tile_end) cur_bank <= ~cur_bank;
      if (wr_en && !accept) err_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fm_mem_wr_ctrl.sv
// Bench for fm_mem_wr_ctrl: transaction-level model compared every cycle,
// plus literal expectations at the interesting points.
module tb_fm_mem_wr_ctrl;
  localparam int WW = 144;

  logic          sys_clk, rstn, cfg_valid, wr_en;
  logic [7:0]    cfg_width, cfg_height;
  logic [11:0]   cfg_stride;
  logic [WW-1:0] wr_data, mem_wr_data;
  logic [1:0]    bank_release, bank_full;
  logic [12:0]   mem_wr_addr;
  logic          mem_wr_en, tile_done, err_overflow;

  int checks = 0, failures = 0;

  fm_mem_wr_ctrl dut (
    .sys_clk(sys_clk), .rstn(rstn), .cfg_valid(cfg_valid),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
    .wr_data(wr_data), .wr_en(wr_en), .bank_release(bank_release),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .bank_full(bank_full), .tile_done(tile_done), .err_overflow(err_overflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: a tile is a flat word index; address = row*stride + col mod bank size.
  int            m_w, m_h, m_s, m_idx;
  bit            m_have, m_bank;
  bit [1:0]      m_full;
  logic          e_en, e_done, e_err;
  logic [12:0]   e_addr;
  logic [WW-1:0] e_data;

  always @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      m_w = 0; m_h = 0; m_s = 0; m_idx = 0;
      m_have = 0; m_bank = 0; m_full = 2'b00;
      e_en = 0; e_done = 0; e_err = 0; e_addr = '0; e_data = '0;
    end else begin
      bit       filling, honour, take;
      bit [1:0] nf;
      filling = m_have && !m_full[m_bank];
      honour  = cfg_valid && (!filling || m_idx == 0);
      take    = filling && wr_en;
      nf      = m_full & ~bank_release;
      e_en    = take;
      e_done  = 0;
      if (wr_en && !take) e_err = 1;
      if (take) begin
        e_addr = {m_bank, 12'((m_idx / m_w) * m_s + (m_idx % m_w))};
        e_data = wr_data;
        m_idx++;
        if (m_idx == m_w * m_h) begin
          e_done       = 1;
          nf[m_bank]   = 1'b1;
          m_bank       = ~m_bank;
          m_idx        = 0;
        end
      end
      if (honour) begin
        m_w = int'(cfg_width); m_h = int'(cfg_height); m_s = int'(cfg_stride);
        m_idx = 0; m_have = 1;
      end
      m_full = nf;
    end
  end

  always @(negedge sys_clk) begin
    chk("wr_en", {143'd0, mem_wr_en}, {143'd0, e_en});
    chk("tile_done", {143'd0, tile_done}, {143'd0, e_done});
    chk("err_overflow", {143'd0, err_overflow}, {143'd0, e_err});
    chk("bank_full", {142'd0, bank_full}, {142'd0, e_full_q()});
    if (e_en) begin
      chk("wr_addr", {131'd0, mem_wr_addr}, {131'd0, e_addr});
      chk("wr_data", mem_wr_data, e_data);
    end
  end

  function automatic logic [1:0] e_full_q();
    return m_full;
  endfunction

  task automatic cyc(input logic w, input logic [1:0] rel, input logic c);
    wr_en = w; bank_release = rel; cfg_valid = c;
    wr_data = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
    @(posedge sys_clk); #1;
    wr_en = 0; bank_release = 2'b00; cfg_valid = 0;
  endtask

  task automatic cfg(input int w, input int h, input int s);
    cfg_width = 8'(w); cfg_height = 8'(h); cfg_stride = 12'(s);
    cyc(0, 2'b00, 1);
  endtask

  task automatic pin(input string name, input int act, input int exp);
    chk(name, WW'(act), WW'(exp));
  endtask

  initial begin
    int exp1[8] = '{0, 1, 2, 3, 8, 9, 10, 11};
    rstn = 0; cfg_valid = 0; wr_en = 0; bank_release = 0;
    cfg_width = 0; cfg_height = 0; cfg_stride = 0; wr_data = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    pin("rst_bank_full", int'(bank_full), 0);
    pin("rst_addr", int'(mem_wr_addr), 0);
    pin("rst_err", int'(err_overflow), 0);
    rstn = 1;

    // 4x2 stride 8 in bank 0, then an immediate second tile in bank 1.
    cfg(4, 2, 8);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 2'b00, 0);
      pin("t1_addr", int'(mem_wr_addr), exp1[i]);
      pin("t1_done", int'(tile_done), (i == 7) ? 1 : 0);
    end
    pin("t1_bank_full", int'(bank_full), 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 2'b00, 0);
      if (i == 0) pin("t2_first_addr", int'(mem_wr_addr), 4096);
    end
    pin("t2_bank_full", int'(bank_full), 3);
    cyc(1, 2'b00, 0);
    pin("drop_wr_en", int'(mem_wr_en), 0);
    pin("drop_err", int'(err_overflow), 1);
    cyc(0, 2'b00, 0);

    // Release bank 0 at t, word at t+1.
    cyc(0, 2'b01, 0);
    pin("rel_full", int'(bank_full), 2);
    cyc(1, 2'b00, 0);
    pin("rel_wr_en", int'(mem_wr_en), 1);
    pin("rel_addr", int'(mem_wr_addr), 0);
    cyc(1, 2'b00, 0);
    cyc(1, 2'b00, 0);
    cfg(2, 2, 1);
    for (int i = 0; i < 5; i++) cyc(1, 2'b00, 0);
    pin("midcfg_last_addr", int'(mem_wr_addr), 11);
    pin("midcfg_done", int'(tile_done), 1);

    // Free both banks, fill bank 1, then a wrapping tile in bank 0.
    cyc(0, 2'b11, 0);
    for (int i = 0; i < 8; i++) cyc(1, 2'b00, 0);
    pin("b1_last_addr", int'(mem_wr_addr), 4096 + 11);
    cfg(200, 3, 4000);
    for (int i = 0; i < 600; i++) begin
      cyc(1, 2'b00, 0);
      if (i == 200) pin("wrap_row1", int'(mem_wr_addr), 4000);
      if (i == 400) pin("wrap_row2", int'(mem_wr_addr), 3904);
    end
    pin("wrap_done", int'(tile_done), 1);

    // Reset mid-tile.
    cyc(0, 2'b11, 0);
    cfg(4, 2, 8);
    for (int i = 0; i < 5; i++) cyc(1, 2'b00, 0);
    rstn = 0;
    #2;
    pin("mrst_en", int'(mem_wr_en), 0);
    pin("mrst_addr", int'(mem_wr_addr), 0);
    pin("mrst_full", int'(bank_full), 0);
    pin("mrst_done", int'(tile_done), 0);
    @(posedge sys_clk); #1;
    rstn = 1;
    cyc(1, 2'b00, 0);
    pin("post_rst_err", int'(err_overflow), 1);
    pin("post_rst_en", int'(mem_wr_en), 0);
    repeat (2) cyc(0, 2'b00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
